// File: rtl/display_scanner_pkg.sv
// Shared constants, FSM state encoding and the anode decode helper for the
// display_scanner block and its serial binary-to-BCD converter.
package display_scanner_pkg;

    localparam int          DIGITS    = 4;
    localparam logic [3:0]  BLANK     = 4'hF;
    localparam logic [13:0] MAX_VALUE = 14'd9999;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    // Active-low one-hot anode enable for a slot index.
    function automatic logic [DIGITS-1:0] anode_onehot(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/display_scanner_bin2bcd_serial.sv
// Serial shift-add-3 converter: 14 data bits -> four packed BCD digits,
// one bit per cycle, with an overflow short-cut for values above 9999.
module bin2bcd_serial
    import display_scanner_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [13:0] i_value,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_ovf,
    output logic [15:0] o_digits
);

    state_t      r_state, w_state_next;
    logic [13:0] r_shift, w_shift_next;
    logic [15:0] r_acc,   w_acc_next, w_acc_adj;
    logic [3:0]  r_cnt,   w_cnt_next;
    logic        r_ovf_pend, w_ovf_pend_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_acc      <= w_acc_next;
            r_cnt      <= w_cnt_next;
            r_ovf_pend <= w_ovf_pend_next;
        end
    end

    // NOTE: every combinational output is given a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_acc_adj = r_acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5)
                w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_acc_next      = r_acc;
        w_cnt_next      = r_cnt;
        w_ovf_pend_next = r_ovf_pend;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_shift_next = i_value;
                    w_acc_next   = '0;
                    w_cnt_next   = 4'd13;
                    if (i_value > MAX_VALUE) begin
                        w_ovf_pend_next = 1'b1;
                        w_state_next    = COMMIT;
                    end else begin
                        w_ovf_pend_next = 1'b0;
                        w_state_next    = CONVERT;
                    end
                end
            end
            CONVERT: begin
                w_acc_next   = {w_acc_adj[14:0], r_shift[13]};
                w_shift_next = {r_shift[12:0], 1'b0};
                w_cnt_next   = r_cnt - 4'd1;
                if (r_cnt == 4'd0)
                    w_state_next = COMMIT;
            end
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign o_busy   = (r_state != IDLE);
    assign o_done   = (r_state == COMMIT);
    assign o_ovf    = r_ovf_pend;
    assign o_digits = r_ovf_pend ? {DIGITS{BLANK}} : r_acc;

endmodule

// File: rtl/display_scanner.sv
// Four-digit common-anode display driver: holds committed BCD digits, applies
// leading-zero blanking and scans one digit per REFRESH_DIV clock cycles.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] value,
    input  logic        load,
    output logic        busy,
    output logic        ovf,
    output logic [3:0]  bcd,
    output logic [3:0]  an
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic          w_done, w_ovf;
    logic [15:0]   w_digits, w_shown;
    logic          w_zero_above;
    logic [15:0]   r_digits;
    logic          r_ovf;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;

    bin2bcd_serial u_conv (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_load   (load),
        .i_value  (value),
        .o_busy   (busy),
        .o_done   (w_done),
        .o_ovf    (w_ovf),
        .o_digits (w_digits)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= '0;
            r_ovf    <= 1'b0;
        end else if (w_done) begin
            r_digits <= w_digits;
            r_ovf    <= w_ovf;
        end
    end

    // Free-running slot scanner; never waits on the converter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (r_presc == PW'(REFRESH_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Blank digit i when it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        w_shown      = r_digits;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (r_digits[4*i +: 4] == 4'd0);
            if (w_zero_above)
                w_shown[4*i +: 4] = BLANK;
        end
    end

    assign ovf = r_ovf;
    assign an  = anode_onehot(r_idx);
    assign bcd = w_shown[4*r_idx +: 4];

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with REFRESH_DIV=4: vector table of
// loads with expected per-slot digits, plus hand-written timing sequences.
module tb_display_scanner;

    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic        ovf;
    logic [3:0]  bcd;
    logic [3:0]  an;

    int n_checks = 0;
    int n_errors = 0;

    display_scanner #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .value (value),
        .load  (load),
        .busy  (busy),
        .ovf   (ovf),
        .bcd   (bcd),
        .an    (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] val;
        logic [15:0] disp;      // slot3..slot0 nibbles as shown on the display
        logic        exp_ovf;
        int          busy_cyc;
    } vec_t;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] exp_an(input int k);
        logic [3:0] one;
        one = 4'b0001 << k;
        return ~one;
    endfunction

    // Visit each slot (bounded wait) and compare the digit shown there.
    task automatic check_display(input string name, input logic [15:0] disp);
        int w;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (an !== exp_an(k) && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (w >= 40) begin
                check($sformatf("%s slot%0d timeout an", name, k), {12'h0, an}, {12'h0, exp_an(k)});
            end else begin
                check($sformatf("%s slot%0d bcd", name, k), {12'h0, bcd}, {12'h0, disp[4*k +: 4]});
            end
        end
    endtask

    // Pulse load for one cycle and count the cycles busy stays high.
    task automatic do_load(input logic [13:0] v, output int cyc);
        @(negedge clk);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc  = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    vec_t vecs[6];
    int   cyc;

    initial begin
        vecs[0] = '{14'd1234,  16'h1234, 1'b0, 15};
        vecs[1] = '{14'd9999,  16'h9999, 1'b0, 15};
        vecs[2] = '{14'd10000, 16'hFFFF, 1'b1, 1};
        vecs[3] = '{14'd0,     16'hFFF0, 1'b0, 15};
        vecs[4] = '{14'd7,     16'hFFF7, 1'b0, 15};
        vecs[5] = '{14'd105,   16'hF105, 1'b0, 15};

        rst_n = 1'b0;
        value = '0;
        load  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-run after reset: slot changes every 4 edges.
        for (int k = 0; k < 16; k++) begin
            #1;
            check($sformatf("reset scan an k=%0d", k), {12'h0, an}, {12'h0, exp_an(k / 4)});
            check($sformatf("reset scan bcd k=%0d", k), {12'h0, bcd}, (k / 4 == 0) ? 16'h0 : 16'hF);
            check($sformatf("reset busy k=%0d", k), {15'h0, busy}, 16'h0);
            check($sformatf("reset ovf k=%0d", k), {15'h0, ovf}, 16'h0);
            @(negedge clk);
        end

        foreach (vecs[i]) begin
            do_load(vecs[i].val, cyc);
            check($sformatf("vec%0d busy cycles", i), cyc[15:0], vecs[i].busy_cyc[15:0]);
            check($sformatf("vec%0d ovf", i), {15'h0, ovf}, {15'h0, vecs[i].exp_ovf});
            check_display($sformatf("vec%0d", i), vecs[i].disp);
        end

        // Second load during conversion is dropped.
        @(negedge clk);
        value = 14'd1234;
        load  = 1'b1;
        @(negedge clk);                 // after E0
        load = 1'b0;
        repeat (4) @(negedge clk);      // after E4
        value = 14'd5678;
        load  = 1'b1;
        @(negedge clk);                 // after E5
        load = 1'b0;
        cyc  = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("ignored load busy tail", cyc[15:0], 16'd10);
        check_display("ignored load", 16'h1234);

        // Load held high: re-accepted on the cycle busy falls.
        @(negedge clk);
        value = 14'd1111;
        load  = 1'b1;
        repeat (15) @(negedge clk);     // after E0..E14
        check("held load busy before E15", {15'h0, busy}, 16'h1);
        @(negedge clk);                 // after E15
        check("held load busy after E15", {15'h0, busy}, 16'h0);
        value = 14'd2222;
        @(negedge clk);                 // after E16: second conversion accepted
        check("held load restarts", {15'h0, busy}, 16'h1);
        load = 1'b0;
        check_display("held load first value", 16'h1111);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        check("held load finished", {15'h0, busy}, 16'h0);
        check_display("held load second value", 16'h2222);

        // Reset mid-conversion at E8.
        @(negedge clk);
        value = 14'd4321;
        load  = 1'b1;
        @(negedge clk);                 // after E0
        load = 1'b0;
        repeat (7) @(negedge clk);      // after E7
        rst_n = 1'b0;
        #1;
        check("midreset busy", {15'h0, busy}, 16'h0);
        check("midreset ovf", {15'h0, ovf}, 16'h0);
        check("midreset an", {12'h0, an}, 16'hE);
        check("midreset bcd", {12'h0, bcd}, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_load(14'd42, cyc);
        check("post-reset busy cycles", cyc[15:0], 16'd15);
        check_display("post-reset 42", 16'hFF42);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
